// File: rtl/int_controller_if.sv
// Control-unit side of the interrupt controller: request/acknowledge and
// return-from-interrupt signalling.
interface int_controller_if #(
  parameter int VEC_W = 2
);
  // int_req_o acts as valid and int_ack_i as ready: once raised, int_req_o and
  // int_vec_o hold steady until the enabled edge on which int_ack_i is seen high.
  // reti_i is only meaningful while in_service_o is high.
  logic             int_req_o;
  logic [VEC_W-1:0] int_vec_o;
  logic             in_service_o;
  logic             int_ack_i;
  logic             reti_i;

  modport master (
    output int_req_o,
    output int_vec_o,
    output in_service_o,
    input  int_ack_i,
    input  reti_i
  );

  modport slave (
    input  int_req_o,
    input  int_vec_o,
    input  in_service_o,
    output int_ack_i,
    output reti_i
  );
endinterface

// File: rtl/int_controller.sv
// Interrupt controller: synchronizes and edge-detects irq lines, latches them as
// pending, masks, picks the lowest-index winner and tracks one in-service handler.
module int_controller #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_dat_i,
  output logic [NUM_SRC-1:0] mask_o,
  output logic [NUM_SRC-1:0] pend_o,
  output logic [1:0]         state_o,
  int_controller_if.master   cu
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_prev_q;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clr;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   win_idx;
  logic               win_valid;

  // The extra sync_prev_q stage gives edge history so a held level yields one event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_prev_q <= '0;
    end else if (cen) begin
      sync_q[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign active   = pend_q & mask_q;

  // Descending scan so the lowest active index is the last assignment.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_idx   = VEC_W'(i);
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          vec_d   = win_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cu.int_ack_i) begin
          clr     = NUM_SRC'(1) << vec_q;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (cu.reti_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge on the source being acknowledged keeps it pending.
  assign pend_d = (pend_q & ~clr) | edge_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else if (cen) begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pend_q  <= pend_d;
      if (mask_we_i) mask_q <= mask_dat_i;
    end
  end

  assign cu.int_req_o    = (state_q == REQ);
  assign cu.in_service_o = (state_q == SERVICE);
  assign cu.int_vec_o    = vec_q;
  assign mask_o          = mask_q;
  assign pend_o          = pend_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios plus randomized traffic, all
// compared each cycle against a sample-history reference model.
module tb_int_controller;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen;
  logic [N-1:0]  irq;
  logic          mask_we;
  logic [N-1:0]  mask_dat;
  logic [N-1:0]  mask_o;
  logic [N-1:0]  pend_o;
  logic [1:0]    state_o;

  int_controller_if #(.VEC_W(VW)) cu_if ();

  int_controller #(
    .NUM_SRC(N),
    .SYNC_STAGES(S),
    .VEC_W(VW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .irq_i      (irq),
    .mask_we_i  (mask_we),
    .mask_dat_i (mask_dat),
    .mask_o     (mask_o),
    .pend_o     (pend_o),
    .state_o    (state_o),
    .cu         (cu_if.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];
  logic prev_svc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_hist[0] is the irq value sampled at the most recent enabled edge.
  logic [N-1:0]  m_hist[$];
  logic [N-1:0]  m_pend;
  logic [N-1:0]  m_mask;
  logic [VW-1:0] m_vec;
  bit            m_req;
  bit            m_svc;

  task automatic model_reset();
    m_hist.delete();
    repeat (S + 1) m_hist.push_back('0);
    m_pend = '0;
    m_mask = '0;
    m_vec  = '0;
    m_req  = 0;
    m_svc  = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] ev;
    logic [N-1:0] cand;
    logic [N-1:0] clr;
    ev   = m_hist[S-1] & ~m_hist[S];
    cand = m_pend & m_mask;
    clr  = '0;
    if (m_req) begin
      if (cu_if.int_ack_i) begin
        clr[m_vec] = 1'b1;
        m_req = 0;
        m_svc = 1;
        exp_q.push_back(m_vec);
      end
    end else if (m_svc) begin
      if (cu_if.reti_i) m_svc = 0;
    end else if (cand != '0) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          m_vec = VW'(i);
          break;
        end
      end
      m_req = 1;
    end
    m_pend = (m_pend & ~clr) | ev;
    if (mask_we) m_mask = mask_dat;
    m_hist.push_front(irq);
    void'(m_hist.pop_back());
  endtask

  task automatic compare_all();
    logic [VW-1:0] e;
    check("req",   cu_if.int_req_o,    m_req);
    check("vec",   cu_if.int_vec_o,    m_vec);
    check("svc",   cu_if.in_service_o, m_svc);
    check("pend",  pend_o,             m_pend);
    check("mask",  mask_o,             m_mask);
    if (cu_if.in_service_o && !prev_svc) begin
      check("sb_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_vec", cu_if.int_vec_o, e);
      end
    end
    prev_svc = cu_if.in_service_o;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst && cen) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we  = 1'b1;
    mask_dat = m;
    tick();
    mask_we  = 1'b0;
  endtask

  task automatic pulse_ack();
    cu_if.int_ack_i = 1'b1;
    tick();
    cu_if.int_ack_i = 1'b0;
  endtask

  task automatic pulse_reti();
    cu_if.reti_i = 1'b1;
    tick();
    cu_if.reti_i = 1'b0;
  endtask

  // Called at a falling edge; asserts reset between edges.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("arst_req",  cu_if.int_req_o,    0);
    check("arst_svc",  cu_if.in_service_o, 0);
    check("arst_pend", pend_o,             0);
    check("arst_mask", mask_o,             0);
    check("arst_vec",  cu_if.int_vec_o,    0);
    model_reset();
    prev_svc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    cen = 1'b1;
    irq = '1;
    mask_we = 1'b0;
    mask_dat = '0;
    cu_if.int_ack_i = 1'b0;
    cu_if.reti_i = 1'b0;
    prev_svc = 1'b0;
    model_reset();

    // Reset with all lines high
    repeat (2) @(negedge clk);
    check("rst_req",  cu_if.int_req_o,    0);
    check("rst_svc",  cu_if.in_service_o, 0);
    check("rst_pend", pend_o,             0);
    check("rst_mask", mask_o,             0);
    check("rst_vec",  cu_if.int_vec_o,    0);
    rst = 1'b1;
    irq = '0;
    repeat (10) tick();
    check("idle_req", cu_if.int_req_o, 0);

    // Single interrupt on source 2, four-edge latency
    write_mask(4'b1111);
    irq[2] = 1'b1;
    repeat (3) tick();
    check("lat3_req", cu_if.int_req_o, 0);
    tick();
    check("lat4_req", cu_if.int_req_o, 1);
    check("lat4_vec", cu_if.int_vec_o, 2);
    pulse_ack();
    check("ack_req",   cu_if.int_req_o,    0);
    check("ack_pend2", pend_o[2],          0);
    check("ack_svc",   cu_if.in_service_o, 1);
    pulse_reti();
    check("reti_svc",  cu_if.in_service_o, 0);

    // Priority, back-to-back gap, no preemption
    irq = '0;
    repeat (4) tick();
    irq = 4'b1010;
    repeat (4) tick();
    check("prio_req", cu_if.int_req_o, 1);
    check("prio_vec", cu_if.int_vec_o, 1);
    pulse_ack();
    pulse_reti();
    check("gap_req", cu_if.int_req_o, 0);
    tick();
    check("b2b_req", cu_if.int_req_o, 1);
    check("b2b_vec", cu_if.int_vec_o, 3);
    irq[0] = 1'b1;
    repeat (5) tick();
    check("nopre_vec",  cu_if.int_vec_o, 3);
    check("nopre_pend", pend_o[0],       1);
    pulse_ack();
    pulse_reti();
    tick();
    check("next_vec", cu_if.int_vec_o, 0);
    pulse_ack();
    pulse_reti();

    // Masking keeps pending bits
    irq = '0;
    repeat (4) tick();
    write_mask(4'b0000);
    irq[0] = 1'b1;
    repeat (4) tick();
    check("msk_pend", pend_o,          4'b0001);
    check("msk_req",  cu_if.int_req_o, 0);
    write_mask(4'b0001);
    check("unmsk1_req", cu_if.int_req_o, 0);
    tick();
    check("unmsk2_req", cu_if.int_req_o, 1);
    check("unmsk2_vec", cu_if.int_vec_o, 0);
    pulse_ack();
    pulse_reti();
    write_mask(4'b1111);

    // Set/clear collision on source 1
    irq = '0;
    repeat (4) tick();
    irq[1] = 1'b1;
    repeat (4) tick();
    check("col_req", cu_if.int_req_o, 1);
    check("col_vec", cu_if.int_vec_o, 1);
    irq[1] = 1'b0;
    repeat (3) tick();
    irq[1] = 1'b1;
    repeat (2) tick();
    pulse_ack();
    check("col_pend1", pend_o[1],          1);
    check("col_svc",   cu_if.in_service_o, 1);
    pulse_reti();
    tick();
    check("col2_req", cu_if.int_req_o, 1);
    check("col2_vec", cu_if.int_vec_o, 1);
    pulse_ack();
    pulse_reti();

    // Clock enable gating, then async reset mid-request
    irq = '0;
    repeat (4) tick();
    cen = 1'b0;
    irq[2] = 1'b1;
    repeat (20) tick();
    check("cen_req",  cu_if.int_req_o, 0);
    check("cen_pend", pend_o,          0);
    cen = 1'b1;
    repeat (3) tick();
    check("cen3_req", cu_if.int_req_o, 0);
    tick();
    check("cen4_req", cu_if.int_req_o, 1);
    check("cen4_vec", cu_if.int_vec_o, 2);
    async_reset();
    tick();
    check("post_rst_req", cu_if.int_req_o, 0);

    // Randomized traffic
    write_mask(4'b1111);
    for (int c = 0; c < 2000; c++) begin
      cen = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      end
      mask_we         = ($urandom_range(0, 15) == 0);
      mask_dat        = N'($urandom_range(0, (1 << N) - 1));
      cu_if.int_ack_i = ($urandom_range(0, 2) == 0);
      cu_if.reti_i    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end

    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Interrupt controller directly upstream of the control unit.
- Collects asynchronous external interrupt lines, edge-detects and latches them as pending, applies a software mask, and selects the highest-priority source.
- Drives the control unit's int_req input and holds it until the control unit pulses int_ack.
- Tracks the in-service interrupt until return-from-interrupt. No nesting.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..16).
- SYNC_STAGES, 2, synchronizer flops per irq line (>=2).
- VEC_W, $clog2(NUM_SRC) (minimum 1), width of the vector output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cen  in  1  clock enable, same gating as the control unit. All state updates only on rising clk with cen=1.
- irq_i  in  NUM_SRC  asynchronous interrupt lines, rising-edge triggered.
- mask_we_i  in  1  write strobe for the mask register.
- mask_dat_i  in  NUM_SRC  mask write data (1 = enabled).
- mask_o  out  NUM_SRC  current mask register.
- pend_o  out  NUM_SRC  current pending register.
- int_ack_i  in  1  from control unit int_ack: request accepted.
- reti_i  in  1  from control unit reti: handler finished.
- int_req_o  out  1  to control unit int_req.
- int_vec_o  out  VEC_W  index of the requested / in-service source.
- in_service_o  out  1  high while a handler is active.

Behaviour:
- Reset (rst=0, asynchronous):
  - synchronizers, edge history, pend_o, mask_o, int_vec_o = 0.
  - int_req_o = 0, in_service_o = 0, state = IDLE.
  - Reset mid-request drops the request immediately.
- Synchronizer and edge detect:
  - Each irq_i bit passes through a SYNC_STAGES flop chain.
  - Edge = sync_out & ~sync_prev.
  - An edge sets pend[i] on the same enabled edge at which it is detected.
  - Pulses shorter than one enabled sample period may be lost.
- Mask:
  - mask_we_i=1 loads mask_dat_i on the enabled edge.
  - Masking never clears pending bits; a masked pending bit is serviced once it is unmasked.
- Priority: lowest index wins among (pend & mask).
- State machine, all transitions on enabled edges:
  - IDLE: if (pend & mask) != 0, latch the winning index into int_vec_o, set int_req_o=1, go to REQ. Otherwise stay.
  - REQ:
    - int_req_o held at 1; int_vec_o frozen.
    - Mask changes or new higher-priority edges do not change the vector or withdraw the request.
    - On int_ack_i=1: clear pend[int_vec_o], set int_req_o=0 and in_service_o=1, go to SERVICE.
  - SERVICE: on reti_i=1, set in_service_o=0 and go to IDLE. New pending requests wait.
- Latency: int_req_o is high after the (SYNC_STAGES+2)th enabled edge following the irq_i rise (sync chain, pend set, REQ entry). With defaults this is 4 edges.
- Simultaneous clear and set of the same pend bit (ack while a new edge arrives on that source): set wins; the bit stays pending.
- Ignored inputs: int_ack_i outside REQ, and reti_i outside SERVICE.
- Back-to-back requests: reti_i in SERVICE with other bits still pending → IDLE for one cycle, then REQ. Minimum one idle cycle between requests.
- cen=0: all flops, including synchronizers, hold their values; outputs remain stable.
- Level-high irq_i held constantly generates only one pending event.

Test Plan:
- Reset and idle: rst=0 while irq_i=4'b1111 → all outputs 0. Release rst, irq_i=0 for 10 cycles → int_req_o stays 0.
- Single interrupt: mask=4'b1111, irq_i[2] rises → int_req_o=1 and int_vec_o=2 after 4 edges. int_ack_i pulse → int_req_o=0, pend_o[2]=0, in_service_o=1. reti_i → in_service_o=0.
- Priority and no preemption:
  - irq_i[3] and irq_i[1] rise together → int_vec_o=1. Ack, reti → next request has int_vec_o=3.
  - irq_i[0] rising during REQ for source 3 → vector stays 3.
- Masking: mask=4'b0000, irq_i[0] rises → pend_o=4'b0001, int_req_o=0. Write mask=4'b0001 → int_req_o=1 with int_vec_o=0 two edges later.
- Set/clear collision: in REQ on source 1, apply a synchronized edge on source 1 in the same cycle as int_ack_i → after ack pend_o[1]=1. After reti_i, a second request is made on source 1.
- cen gating and async reset: cen=0 with irq_i[2] rising → no state change for 20 cycles. cen=1 → request after 4 edges. Assert rst=0 mid-REQ between clock edges → int_req_o drops immediately.
